// File: rtl/cia_pkg.sv
// Shared definitions for the sequential carry-increment subtractor.
// Holds the FSM state encoding and a constant log2 helper for index widths.
// No logic of its own; imported by the top and the slice block.
package cia_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, used only on elaboration-time constants.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cia_block.sv
// One carry-increment slice: ripple sum assuming cin=0, then a +1 chain when cin=1.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the owning FSM decides when the result is registered.
module cia_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] x,
    input  logic [BLOCK-1:0] y,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout
);

    logic [BLOCK-1:0] sum0;
    logic             c0;
    logic             inc;

    // Ripple sum with carry-in forced to 0, then conditional increment by cin.
    always_comb begin
        sum0 = '0;
        c0   = 1'b0;
        s    = '0;
        inc  = cin;
        for (int i = 0; i < BLOCK; i++) begin
            sum0[i] = x[i] ^ y[i] ^ c0;
            c0      = (x[i] & y[i]) | (c0 & (x[i] ^ y[i]));
        end
        // The increment ripples only through the run of ones at the bottom of sum0.
        for (int i = 0; i < BLOCK; i++) begin
            s[i] = sum0[i] ^ inc;
            inc  = inc & sum0[i];
        end
        cout = c0 | inc;
    end

endmodule

// File: rtl/carry_increment_subtractor_seq.sv
// Multi-cycle subtractor: diff = a + ~b + ~borrow_in, one BLOCK-bit slice per clock.
// Latency: out_valid rises NUM_BLK clocks after the operand accept edge.
// Backpressure: result held in DONE until out_ready; no operands accepted until back in IDLE.
module carry_increment_subtractor_seq
    import cia_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int NUM_BLK = WIDTH / BLOCK;
    localparam int IW      = (NUM_BLK > 1) ? clog2(NUM_BLK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BLK - 1);
    localparam int MSB     = WIDTH - 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] nb_q;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [BLOCK-1:0] x_sl;
    logic [BLOCK-1:0] y_sl;
    logic [BLOCK-1:0] s_sl;
    logic             c_out;
    logic [WIDTH-1:0] diff_nxt;
    logic             ovf_nxt;
    logic             last_slice;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign last_slice = (idx == LAST_IDX);

    // Select the current slice of the latched operands.
    assign x_sl = a_q[int'(idx) * BLOCK +: BLOCK];
    assign y_sl = nb_q[int'(idx) * BLOCK +: BLOCK];

    cia_block #(
        .BLOCK(BLOCK)
    ) u_block (
        .x    (x_sl),
        .y    (y_sl),
        .cin  (carry),
        .s    (s_sl),
        .cout (c_out)
    );

    // Result as it will look once the current slice is written; overflow uses the final MSB.
    // nb_q holds ~b, so a[MSB] != b[MSB] is a[MSB] == nb_q[MSB].
    always_comb begin
        diff_nxt = diff;
        diff_nxt[int'(idx) * BLOCK +: BLOCK] = s_sl;
        ovf_nxt  = (a_q[MSB] == nb_q[MSB]) && (diff_nxt[MSB] != a_q[MSB]);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept -> walk slices -> hold until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = BUSY;
            BUSY:    if (last_slice) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, per-slice carry chain and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            nb_q       <= '0;
            carry      <= 1'b0;
            idx        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        nb_q  <= ~b;
                        carry <= ~borrow_in;
                        idx   <= '0;
                    end
                end
                BUSY: begin
                    diff  <= diff_nxt;
                    carry <= c_out;
                    idx   <= idx + IW'(1);
                    if (last_slice) begin
                        borrow_out <= ~c_out;
                        overflow   <= ovf_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carry_increment_subtractor_seq.sv
// Directed bench for the sequential subtractor at 16/4 and 32/8.
// Latency, backpressure hold, mid-operation reset and wrap-around cases.
// Outputs are sampled 1 time unit after each rising edge.
module tb_carry_increment_subtractor_seq;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit / 4-bit instance
    logic        rst16, iv16, ir16, bin16, ov16, or16, bo16, of16;
    logic [15:0] a16, b16, d16;
    // 32-bit / 8-bit instance
    logic        rst32, iv32, ir32, bin32, ov32, or32, bo32, of32;
    logic [31:0] a32, b32, d32;

    int checks = 0;
    int errors = 0;

    carry_increment_subtractor_seq #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clk(clk), .rst_n(rst16), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .borrow_in(bin16), .out_valid(ov16),
        .out_ready(or16), .diff(d16), .borrow_out(bo16), .overflow(of16)
    );

    carry_increment_subtractor_seq #(.WIDTH(32), .BLOCK(8)) dut32 (
        .clk(clk), .rst_n(rst32), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .borrow_in(bin32), .out_valid(ov32),
        .out_ready(or32), .diff(d32), .borrow_out(bo32), .overflow(of32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation on the 16-bit instance, wait for the result, check, consume.
    task automatic op16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic bi, input logic [15:0] ed, input logic eb, input logic eo);
        int lat;
        check({tag, ".in_ready"}, {31'd0, ir16}, 32'd1);
        a16 = av; b16 = bv; bin16 = bi; iv16 = 1'b1;
        tick();
        iv16 = 1'b0; a16 = 16'h5A5A; b16 = 16'hA5A5; bin16 = ~bi;
        lat = 0;
        while (!ov16 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, lat, 32'd4);
        check({tag, ".diff"}, {16'd0, d16}, {16'd0, ed});
        check({tag, ".borrow"}, {31'd0, bo16}, {31'd0, eb});
        check({tag, ".ovf"}, {31'd0, of16}, {31'd0, eo});
        or16 = 1'b1;
        tick();
        or16 = 1'b0;
        check({tag, ".idle"}, {30'd0, ov16, ir16}, 32'd1);
    endtask

    task automatic op32(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic bi, input logic [31:0] ed, input logic eb, input logic eo);
        int lat;
        check({tag, ".in_ready"}, {31'd0, ir32}, 32'd1);
        a32 = av; b32 = bv; bin32 = bi; iv32 = 1'b1;
        tick();
        iv32 = 1'b0; a32 = 32'h1234_5678; b32 = 32'h8765_4321; bin32 = ~bi;
        lat = 0;
        while (!ov32 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, lat, 32'd4);
        check({tag, ".diff"}, d32, ed);
        check({tag, ".borrow"}, {31'd0, bo32}, {31'd0, eb});
        check({tag, ".ovf"}, {31'd0, of32}, {31'd0, eo});
        or32 = 1'b1;
        tick();
        or32 = 1'b0;
        check({tag, ".idle"}, {30'd0, ov32, ir32}, 32'd1);
    endtask

    initial begin
        logic [15:0] held_d;
        logic        held_b;
        logic        held_o;

        rst16 = 1'b0; rst32 = 1'b0;
        iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
        iv32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0; bin32 = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst.in_ready", {31'd0, ir16}, 32'd1);
        check("rst.out_valid", {31'd0, ov16}, 32'd0);
        check("rst.diff", {16'd0, d16}, 32'd0);
        check("rst.flags", {30'd0, bo16, of16}, 32'd0);
        rst16 = 1'b1; rst32 = 1'b1;
        tick();

        // Basic 16-bit vectors
        op16("t1", 16'h3C4D, 16'h1A2B, 1'b0, 16'h2222, 1'b0, 1'b0);
        op16("t2", 16'h0000, 16'h0001, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        op16("t3", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        op16("wrap", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        op16("self", 16'hBEEF, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0);
        op16("negovf", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

        // Backpressure: 1234 - 4321 = CF13 with borrow, held for 3 cycles
        a16 = 16'h1234; b16 = 16'h4321; bin16 = 1'b0; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("bp.valid", {31'd0, ov16}, 32'd1);
        check("bp.diff", {16'd0, d16}, 32'h0000_CF13);
        check("bp.flags", {30'd0, bo16, of16}, 32'd2);
        held_d = d16; held_b = bo16; held_o = of16;
        iv16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0000; bin16 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp.hold_valid", {31'd0, ov16}, 32'd1);
            check("bp.hold_ready", {31'd0, ir16}, 32'd0);
            check("bp.hold_diff", {16'd0, d16}, {16'd0, held_d});
            check("bp.hold_flags", {30'd0, bo16, of16}, {30'd0, held_b, held_o});
        end
        iv16 = 1'b0; or16 = 1'b1;
        tick();
        or16 = 1'b0;
        check("bp.release", {30'd0, ov16, ir16}, 32'd1);
        for (int i = 0; i < 6; i++) tick();
        check("bp.not_queued", {30'd0, ov16, ir16}, 32'd1);

        // Reset two cycles into an operation
        a16 = 16'h0001; b16 = 16'h0002; bin16 = 1'b0; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        tick();
        tick();
        rst16 = 1'b0;
        #1;
        check("abort.out_valid", {31'd0, ov16}, 32'd0);
        check("abort.diff", {16'd0, d16}, 32'd0);
        check("abort.in_ready", {31'd0, ir16}, 32'd1);
        check("abort.flags", {30'd0, bo16, of16}, 32'd0);
        tick();
        rst16 = 1'b1;
        tick();
        op16("t5", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0);

        // 32-bit / 8-bit instance
        op32("t6", 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 1'b1, 1'b0);
        op32("w32a", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        op32("w32b", 32'h89AB_CDEF, 32'h0123_4567, 1'b1, 32'h8888_8887, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
